// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 serial-interface controller.
// One request: CONVST pulse, conversion wait, 12 SCK periods that shift the
// 6-bit config word out on SDI and the 12-bit result in on SDO, then a
// one-cycle valid strobe. Each result is tagged with the channel sent in
// the previous frame, because the ADC applies a config word to the next
// conversion.
`timescale 1ns/1ps

module adc_ltc2308_ctrl #(
    parameter int SCLK_DIV    = 2,   // clk cycles per SCK half-period
    parameter int CONV_CYCLES = 64,  // clk cycles from CONVST rise to first SCK edge
    parameter int CONVST_HIGH = 2,   // clk cycles CONVST is held high
    parameter bit UNIPOLAR    = 1'b1 // value sent in the UNI config bit
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        start,
    input  logic [2:0]  channel,
    output logic        busy,
    output logic        data_valid,
    output logic [11:0] data,
    output logic [2:0]  data_channel,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int CONV_W   = $clog2(CONV_CYCLES + 1);
    localparam int DIV_W    = $clog2(SCLK_DIV + 1);
    localparam int LAST_HALF = 23; // 12 SCK periods = 24 half-periods

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t              state;
    state_t              next_state;
    logic [CONV_W-1:0]   conv_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [4:0]          half_idx;
    logic [2:0]          cfg_ch;
    logic [2:0]          prev_ch;
    logic [11:0]         sdi_sr;
    logic [11:0]         sdo_sr;

    logic                accept;
    logic                conv_done;
    logic                half_end;
    logic                shift_done;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the per-cycle event decodes the datapath uses.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        next_state = state;
        accept     = 1'b0;
        conv_done  = 1'b0;
        half_end   = 1'b0;
        shift_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = CONV;
                end
            end
            CONV: begin
                if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                    conv_done  = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                    half_end = 1'b1;
                    if (half_idx == 5'(LAST_HALF)) begin
                        shift_done = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
        endcase
        // Lock loss overrides everything: back to IDLE, no events fire.
        if (!pll_locked) begin
            next_state = IDLE;
            accept     = 1'b0;
            conv_done  = 1'b0;
            half_end   = 1'b0;
            shift_done = 1'b0;
        end
    end

    // Registered datapath: counters, serial shifters and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is plain control/data state, so all
            // of it is reset; there is no memory array that would be left
            // unreset.
            busy         <= 1'b1;
            data_valid   <= 1'b0;
            data         <= '0;
            data_channel <= '0;
            adc_convst   <= 1'b0;
            adc_sck      <= 1'b0;
            adc_sdi      <= 1'b0;
            conv_cnt     <= '0;
            div_cnt      <= '0;
            half_idx     <= '0;
            cfg_ch       <= '0;
            prev_ch      <= '0; // ADC powers up on CH0
            sdi_sr       <= '0;
            sdo_sr       <= '0;
        end else begin
            busy       <= (next_state != IDLE) || !pll_locked;
            data_valid <= 1'b0;
            if (!pll_locked) begin
                // Abort: the frame's config counts as not sent.
                adc_convst <= 1'b0;
                adc_sck    <= 1'b0;
                adc_sdi    <= 1'b0;
                cfg_ch     <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            cfg_ch     <= channel;
                            conv_cnt   <= '0;
                            adc_convst <= (CONVST_HIGH > 0);
                            // S/D, O/S, S1, S0, UNI, SLP then six zero bits.
                            sdi_sr     <= {1'b1, channel[0], channel[2], channel[1],
                                           UNIPOLAR, 1'b0, 6'b0};
                        end
                    end
                    CONV: begin
                        conv_cnt   <= conv_cnt + 1'b1;
                        adc_convst <= (int'(conv_cnt) + 1 < CONVST_HIGH);
                        if (conv_done) begin
                            // First low half of SCK begins; SDI gets bit 1.
                            adc_convst <= 1'b0;
                            div_cnt    <= '0;
                            half_idx   <= '0;
                            adc_sck    <= 1'b0;
                            adc_sdi    <= sdi_sr[11];
                            sdi_sr     <= {sdi_sr[10:0], 1'b0};
                        end
                    end
                    SHIFT: begin
                        if (half_end) begin
                            div_cnt  <= '0;
                            half_idx <= half_idx + 5'd1;
                            if (shift_done) begin
                                adc_sck <= 1'b0;
                                adc_sdi <= 1'b0;
                            end else if (!half_idx[0]) begin
                                // Low half ends: SCK rises, capture SDO.
                                adc_sck <= 1'b1;
                                sdo_sr  <= {sdo_sr[10:0], adc_sdo};
                            end else begin
                                // High half ends: SCK falls, next SDI bit.
                                adc_sck <= 1'b0;
                                adc_sdi <= sdi_sr[11];
                                sdi_sr  <= {sdi_sr[10:0], 1'b0};
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        data         <= sdo_sr;
                        data_channel <= prev_ch;
                        prev_ch      <= cfg_ch;
                        data_valid   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/adc_ltc2308_ctrl.md
# adc_ltc2308_ctrl

- Serial-interface controller for the board's LTC2308 8-channel 12-bit SAR ADC.
- Runs on the 40 MHz ADC clock from the PLL and treats that PLL's `locked` output as a run-enable.
- On a single-cycle `start` request it:
  - issues a CONVST pulse,
  - waits out the conversion,
  - shifts the 6-bit channel-config word out on SDI while shifting the 12-bit result in on SDO,
  - presents the result with a one-cycle valid strobe to downstream display/filter logic.

## Interface
- `SCLK_DIV`, default 2: clk cycles per SCK half-period. SCK = clk/(2·SCLK_DIV), which is 10 MHz at 40 MHz clk. Minimum 1.
- `CONV_CYCLES`, default 64: clk cycles from CONVST rise to the first SCK edge. Covers tCONV of 1.6 µs at 40 MHz. Minimum 3.
- `CONVST_HIGH`, default 2: clk cycles CONVST is held high.
- `UNIPOLAR`, default 1: value sent in the UNI config bit.
- `clk` in, 1: 40 MHz ADC clock from the PLL.
- `rst_n` in, 1: one clock; reset is asynchronous and active-low.
- `pll_locked` in, 1: PLL lock indication. Low forces the block idle.
- `start` in, 1: conversion request pulse.
- `channel` in, 3: channel for the config word. Sampled when `start` is accepted.
- `busy` out, 1: high when a request cannot be accepted.
- `data_valid` out, 1: one-cycle strobe.
- `data` out, 12: conversion result, unsigned.
- `data_channel` out, 3: channel the result belongs to.
- `adc_convst` out, 1: ADC CONVST.
- `adc_sck` out, 1: ADC SCK. Idles low.
- `adc_sdi` out, 1: ADC SDI. Config word, MSB first.
- `adc_sdo` in, 1: ADC SDO. Result, MSB first.

## Operation
- FSM has four states: IDLE, CONV, SHIFT, DONE.
- IDLE:
  - `busy` = !pll_locked.
  - `start` with pll_locked high is accepted; go to CONV and latch `channel` into cfg_ch.
- CONV:
  - `adc_convst` is high for the first CONVST_HIGH cycles, then low.
  - After CONV_CYCLES cycles in CONV, go to SHIFT.
- SHIFT:
  - 12 SCK periods, each low half then high half, SCLK_DIV cycles per half.
  - `adc_sdi` changes only at the start of a low half.
  - `adc_sdo` is sampled into a shift register on the clk cycle where SCK rises.
  - SDI bits 1–6 are S/D=1, O/S=cfg_ch[0], S1=cfg_ch[2], S0=cfg_ch[1], UNI=UNIPOLAR, SLP=0. SDI is 0 for bits 7–12 and whenever not in SHIFT.
  - After the 12th high half, go to DONE.
- DONE (one cycle):
  - Load `data` with the 12 sampled bits, first-sampled bit = data[11].
  - `data_channel` = prev_ch; then prev_ch ← cfg_ch.
  - `data_valid` = 1. Return to IDLE.
- Result tagging:
  - The LTC2308 applies a config word to the *next* conversion, so each result is tagged with the channel sent in the previous frame.
  - prev_ch resets to 0, because the ADC powers up on CH0.
- `busy` is 1 in CONV, SHIFT and DONE, and in IDLE while pll_locked is low. A `start` while busy is ignored and not queued.
- Lock loss: pll_locked low in any state forces IDLE on the next edge.
  - `adc_convst`, `adc_sck` and `data_valid` drop to 0 and no partial result is presented.
  - cfg_ch is discarded and prev_ch is unchanged.
  - The aborted frame's config counts as not sent.

## Timing
- Reset values: busy=1 (pll_locked assumed low at reset), data_valid=0, data=0, data_channel=0, adc_convst=0, adc_sck=0, adc_sdi=0, prev_ch=0. The FSM resets to IDLE.
- Reset is asynchronous mid-frame: all outputs go to reset values immediately and no data_valid is produced.
- Latency: start accepted at edge 0 → CONVST rises on the same edge → data_valid high at cycle CONV_CYCLES + 24·SCLK_DIV + 1. With defaults that is cycle 113.
- Back-to-back: the earliest next accept is the cycle after data_valid. With defaults, start held high gives one conversion every 114 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset and lock gating: assert rst_n=0 then release with pll_locked=0. Required: all outputs at reset values and busy=1. Pulse start: no CONVST. Raise pll_locked: busy=0 next cycle.
- Single conversion: channel=3, ADC model drives 0xA5C. Required:
  - CONVST high for 2 cycles and SDI bits 1-1-0-1-1-0.
  - Exactly 12 SCK rises at 10 MHz.
  - data_valid at cycle 113 with data=0xA5C, data_channel=0.
- Pipeline tag: a second conversion with channel=5, model drives 0x123. Required: data=0x123, data_channel=3, SDI bits 1-1-1-0-1-0.
- Start while busy: pulse start at cycles 10 and 60 of a frame. Required: one data_valid only, channel unchanged from the first request.
- Lock loss mid-SHIFT: drop pll_locked after 5 SCK rises. Required: SCK/CONVST low the next cycle, no data_valid, busy=1. After relock and a new request: data_channel equals the tag from before the aborted frame.
- Async reset mid-CONV: pull rst_n low at cycle 20. Required: outputs at reset values immediately, no data_valid after release.
